// File: rtl/program_loader_if.sv
// program_loader_if: groups the loader's host byte stream, its instruction
// memory write port and its CPU control/status lines into one bundle.
//
//   Start        host -> loader   begin a load (honoured in IDLE/DONE/ERROR)
//   ByteIn       host -> loader   stream byte
//   ByteValid    host -> loader   ByteIn is valid
//   ByteReady    loader -> host   loader accepts a byte this cycle
//   WriteAddress loader -> memory byte address of the current write
//   WriteData    loader -> memory word to write
//   WriteEnable  loader -> memory one-cycle write strobe
//   CpuHold      loader -> CPU    hold CPU in reset / stalled while high
//   Done         loader -> host   load completed successfully
//   Error        loader -> host   load rejected
//
// The master modport is the host/system side; the slave modport is the loader.
interface program_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Start;
    logic [7:0]            ByteIn;
    logic                  ByteValid;
    logic                  ByteReady;
    logic [DATA_WIDTH-1:0] WriteAddress;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  WriteEnable;
    logic                  CpuHold;
    logic                  Done;
    logic                  Error;

    modport master (
        output Start, ByteIn, ByteValid,
        input  ByteReady, WriteAddress, WriteData, WriteEnable,
        input  CpuHold, Done, Error
    );

    modport slave (
        input  Start, ByteIn, ByteValid,
        output ByteReady, WriteAddress, WriteData, WriteEnable,
        output CpuHold, Done, Error
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: receives a program image as a big-endian byte stream
// (one length word L followed by L data words) and writes it word by word
// into the instruction memory's write port, holding the CPU off until the
// image is complete.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    program_loader_if.slave (byte stream in, memory write port out,
//          CpuHold/Done/Error status out); all outputs are registered.
//
// Parameters:
//   MEMORY_DEPTH  instruction memory depth in words; longest accepted image
//   DATA_WIDTH    word/address width, a multiple of 8
//   BASE_ADDRESS  byte address of the first word written
//
// Optional feature (macro PROGRAM_LOADER_CHECKSUM_EN): after the last data
// word (or straight after a zero length) one extra word C is accepted; the
// load completes only if C equals the modulo-2^DATA_WIDTH sum of the data
// words, otherwise it ends in ERROR. Without the macro the last write (or a
// zero length) goes straight to DONE.
module program_loader #(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(32'h0000_0000)
) (
    input  logic               clk,
    input  logic               reset,
    program_loader_if.slave    bus
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int IW  = $clog2(MEMORY_DEPTH + 1);
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] len_r;
    logic [DATA_WIDTH-1:0] asm_r;
    logic [IW-1:0]         index_r;
    logic [BCW-1:0]        byte_cnt_r;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_r;
`endif

    logic                  xfer_s;
    logic                  last_byte_s;
    logic                  last_word_s;
    logic [DATA_WIDTH-1:0] len_next_s;
    logic [DATA_WIDTH-1:0] word_next_s;

    // Big-endian assembly: earlier bytes migrate towards the MSBs.
    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] word,
        input logic [7:0]            b
    );
        return (word << 8) | DATA_WIDTH'(b);
    endfunction

    assign xfer_s      = bus.ByteValid && bus.ByteReady;
    assign last_byte_s = (byte_cnt_r == BCW'(BPW - 1));
    assign len_next_s  = shift_in(len_r, bus.ByteIn);
    assign word_next_s = shift_in(asm_r, bus.ByteIn);
    assign last_word_s = ((DATA_WIDTH'(index_r) + DATA_WIDTH'(1)) == len_r);

    // Loader FSM: byte collection, write strobing and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= S_IDLE;
            len_r            <= '0;
            asm_r            <= '0;
            index_r          <= '0;
            byte_cnt_r       <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_r            <= '0;
`endif
            bus.ByteReady    <= 1'b0;
            bus.WriteEnable  <= 1'b0;
            bus.WriteAddress <= '0;
            bus.WriteData    <= '0;
            bus.CpuHold      <= 1'b1;
            bus.Done         <= 1'b0;
            bus.Error        <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE, S_ERROR: begin
                    // A new load restarts from a clean slate from any resting state.
                    if (bus.Start) begin
                        state_r       <= S_LEN;
                        len_r         <= '0;
                        asm_r         <= '0;
                        index_r       <= '0;
                        byte_cnt_r    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum_r         <= '0;
`endif
                        bus.ByteReady <= 1'b1;
                        bus.CpuHold   <= 1'b1;
                        bus.Done      <= 1'b0;
                        bus.Error     <= 1'b0;
                    end else begin
                        state_r       <= state_r;
                    end
                end

                S_LEN: begin
                    if (xfer_s) begin
                        len_r <= len_next_s;
                        if (last_byte_s) begin
                            byte_cnt_r <= '0;
                            if (len_next_s == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                                state_r       <= S_CHECK;
`else
                                state_r       <= S_DONE;
                                bus.ByteReady <= 1'b0;
                                bus.CpuHold   <= 1'b0;
                                bus.Done      <= 1'b1;
`endif
                            end else if (len_next_s > DATA_WIDTH'(MEMORY_DEPTH)) begin
                                state_r       <= S_ERROR;
                                bus.ByteReady <= 1'b0;
                                bus.Error     <= 1'b1;
                            end else begin
                                state_r       <= S_DATA;
                                index_r       <= '0;
                            end
                        end else begin
                            byte_cnt_r <= byte_cnt_r + BCW'(1);
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end

                S_DATA: begin
                    if (xfer_s) begin
                        asm_r <= word_next_s;
                        if (last_byte_s) begin
                            // Address/data are registered with the strobe so the
                            // memory sees a coherent triple during WRITE.
                            state_r          <= S_WRITE;
                            byte_cnt_r       <= '0;
                            bus.ByteReady    <= 1'b0;
                            bus.WriteEnable  <= 1'b1;
                            bus.WriteData    <= word_next_s;
                            bus.WriteAddress <= BASE_ADDRESS + (DATA_WIDTH'(index_r) << 2);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            sum_r            <= sum_r + word_next_s;
`endif
                        end else begin
                            byte_cnt_r <= byte_cnt_r + BCW'(1);
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end

                S_WRITE: begin
                    bus.WriteEnable <= 1'b0;
                    asm_r           <= '0;
                    if (last_word_s) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_r       <= S_CHECK;
                        bus.ByteReady <= 1'b1;
`else
                        state_r       <= S_DONE;
                        bus.CpuHold   <= 1'b0;
                        bus.Done      <= 1'b1;
`endif
                    end else begin
                        state_r       <= S_DATA;
                        index_r       <= index_r + IW'(1);
                        bus.ByteReady <= 1'b1;
                    end
                end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer_s) begin
                        asm_r <= word_next_s;
                        if (last_byte_s) begin
                            byte_cnt_r    <= '0;
                            bus.ByteReady <= 1'b0;
                            if (word_next_s == sum_r) begin
                                state_r     <= S_DONE;
                                bus.CpuHold <= 1'b0;
                                bus.Done    <= 1'b1;
                            end else begin
                                state_r     <= S_ERROR;
                                bus.CpuHold <= 1'b1;
                                bus.Error   <= 1'b1;
                            end
                        end else begin
                            byte_cnt_r <= byte_cnt_r + BCW'(1);
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
`endif

                default: begin
                    state_r         <= S_IDLE;
                    bus.ByteReady   <= 1'b0;
                    bus.WriteEnable <= 1'b0;
                    bus.CpuHold     <= 1'b1;
                    bus.Done        <= 1'b0;
                    bus.Error       <= 1'b0;
                end
            endcase
        end
    end

endmodule
